// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end:
// redirect select encodings, fetch FSM states and the queued {pc, inst} entry.
package fetch_unit_pkg;

  localparam logic [2:0]  PC_SEQ    = 3'b000;
  localparam logic [2:0]  PC_JUMP   = 3'b010;
  localparam logic [2:0]  PC_BRANCH = 3'b011;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_queue.sv
// Synchronous FIFO of fetched {pc, inst} entries. Flush has priority over push;
// a push into a full queue is accepted only when a pop frees the head the same cycle.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int QDEPTH = 4,
  localparam int CW = $clog2(QDEPTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(QDEPTH);
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  fetch_entry_t   mem [QDEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           do_push;
  logic           do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset: entries are only visible once count says so.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: fetch PC, imem req/ack requester and a {pc, inst}
// queue feeding decode. Optional macro FETCH_BYPASS_EN forwards ack data straight to decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          QDEPTH   = 4
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  output logic         inst_valid,
  output logic [31:0]  inst,
  output logic [31:0]  inst_pc,
  input  logic         inst_ready,
  input  logic [2:0]   pc_sel,
  input  logic [31:0]  pc_target,
  output fetch_state_t dbg_state
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(QDEPTH);

  // Handshakes: imem_req holds with a stable imem_addr until the cycle imem_ack is
  // high (transfer in that cycle); decode takes the head when inst_valid & inst_ready.

  fetch_state_t  state, state_next;
  logic [31:0]   fetch_pc, fetch_pc_next;
  logic [31:0]   req_addr, req_addr_next;
  logic          redirect;
  logic [31:0]   target_pc;
  logic          unused_target_bits;

  fetch_entry_t  q_head;
  fetch_entry_t  q_push_data;
  logic [CW-1:0] q_count;
  logic [CW-1:0] count_next;
  logic          q_valid;
  logic          q_push;
  logic          q_pop;
  logic          ack_push;
  logic          space;

  assign redirect           = (pc_sel != PC_SEQ);
  assign target_pc          = {pc_target[31:2], 2'b00};
  assign unused_target_bits = ^pc_target[1:0];

  assign q_valid     = (q_count != '0);
  assign q_pop       = q_valid && inst_ready;
  assign ack_push    = (state == F_REQ) && imem_ack && !redirect;
  assign q_push_data = '{pc: fetch_pc, inst: imem_rdata};

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass = ack_push && !q_valid;
  // A bypassed word that decode takes right away never occupies a queue slot.
  assign q_push = ack_push && !(bypass && inst_ready);

  always_comb begin
    inst_valid = 1'b0;
    inst       = '0;
    inst_pc    = '0;
    if (q_valid) begin
      inst_valid = 1'b1;
      inst       = q_head.inst;
      inst_pc    = q_head.pc;
    end else if (bypass) begin
      inst_valid = 1'b1;
      inst       = imem_rdata;
      inst_pc    = fetch_pc;
    end
  end
`else
  assign q_push = ack_push;

  always_comb begin
    inst_valid = 1'b0;
    inst       = '0;
    inst_pc    = '0;
    if (q_valid) begin
      inst_valid = 1'b1;
      inst       = q_head.inst;
      inst_pc    = q_head.pc;
    end
  end
`endif

  // Occupancy after this cycle's flush/push/pop decides whether another request fits.
  always_comb begin
    count_next = '0;
    if (!redirect) count_next = q_count + CW'(q_push) - CW'(q_pop);
  end
  assign space = (count_next < FULL);

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    req_addr_next = req_addr;
    case (state)
      F_IDLE: begin
        if (redirect) begin
          fetch_pc_next = target_pc;
        end else if (space) begin
          state_next    = F_REQ;
          req_addr_next = fetch_pc;
        end
      end
      F_REQ: begin
        if (redirect) begin
          fetch_pc_next = target_pc;
          state_next    = imem_ack ? F_IDLE : F_DROP;
        end else if (imem_ack) begin
          fetch_pc_next = fetch_pc + 32'd4;
          if (space) req_addr_next = fetch_pc + 32'd4;
          else       state_next    = F_IDLE;
        end
      end
      F_DROP: begin
        // Old request must still complete; its data is thrown away.
        if (redirect) fetch_pc_next = target_pc;
        if (imem_ack) state_next    = F_IDLE;
      end
      default: state_next = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= F_IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      req_addr <= req_addr_next;
    end
  end

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .flush     (redirect),
    .head      (q_head),
    .count     (q_count)
  );

  assign imem_req  = (state != F_IDLE);
  assign imem_addr = req_addr;
  assign dbg_state = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run, all checked against
// a program-order model of what decode should see (sequential PCs, restart at redirect target).
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          QD     = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_ack = 1'b0;
  logic [31:0]  imem_rdata = '0;
  logic         inst_valid;
  logic [31:0]  inst;
  logic [31:0]  inst_pc;
  logic         inst_ready = 1'b0;
  logic [2:0]   pc_sel = PC_SEQ;
  logic [31:0]  pc_target = '0;
  fetch_state_t dbg_state;

  fetch_unit #(.RESET_PC(RST_PC), .QDEPTH(QD)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready),
    .pc_sel     (pc_sel),
    .pc_target  (pc_target),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  int consumed = 0;
  int acks = 0;
  logic pending = 1'b0;
  int wait_left = 0;
  logic prev_unacked = 1'b0;
  logic [31:0] prev_addr = '0;
  logic redirect_prev = 1'b0;
  logic obs_req, obs_ack, obs_valid;
  logic [31:0] obs_addr, obs_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h100;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back(RST_PC);
    pending       = 1'b0;
    prev_unacked  = 1'b0;
    redirect_prev = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1; imem_ack = 1'b0; inst_ready = 1'b0; pc_sel = PC_SEQ; pc_target = '0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    check("rst_imem_req",   32'(imem_req),   32'd0);
    check("rst_imem_addr",  imem_addr,       RST_PC);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst",       inst,            32'd0);
    check("rst_inst_pc",    inst_pc,         32'd0);
    check("rst_state",      32'(dbg_state),  32'(F_IDLE));
    reset = 1'b0;
    model_reset();
  endtask

  // One core cycle: drive decode inputs and the memory responder, then check outputs.
  task automatic cycle(input logic rdy, input logic [2:0] sel, input logic [31:0] tgt,
                       input int wmin, input int wmax);
    logic [31:0] e;
    @(negedge clk);
    inst_ready = rdy;
    pc_sel     = sel;
    pc_target  = tgt;
    if (imem_req) begin
      if (!pending) begin
        pending   = 1'b1;
        wait_left = $urandom_range(wmin, wmax);
      end
      imem_ack = (wait_left == 0);
      if (!imem_ack) wait_left--;
      imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom();
    end else begin
      pending    = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = $urandom();
    end
    #1;
    obs_req = imem_req; obs_addr = imem_addr; obs_ack = imem_ack;
    obs_valid = inst_valid; obs_pc = inst_pc;
    if (imem_req) check("addr_align", 32'(imem_addr[1:0]), 32'd0);
    if (imem_req && prev_unacked) check("addr_hold", imem_addr, prev_addr);
    if (redirect_prev) check("valid_after_redirect", 32'(inst_valid), 32'd0);
    if (!inst_valid) begin
      check("idle_inst", inst, 32'd0);
      check("idle_inst_pc", inst_pc, 32'd0);
    end
    if (inst_valid && rdy) begin
      e = exp_q.pop_front();
      check("stream_pc", inst_pc, e);
      check("stream_inst", inst, mem_word(e));
      if (exp_q.size() == 0) exp_q.push_back(e + 32'd4);
      consumed++;
    end
    if (sel != PC_SEQ) begin
      exp_q.delete();
      exp_q.push_back({tgt[31:2], 2'b00});
    end
    redirect_prev = (sel != PC_SEQ);
    if (imem_ack) begin
      pending = 1'b0;
      acks++;
    end
    prev_unacked = imem_req && !imem_ack;
    prev_addr    = imem_addr;
  endtask

  task automatic expect_next_req(input string tag, input logic [31:0] addr);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      cycle(1'b1, PC_SEQ, 32'd0, 0, 0);
      if (obs_req) begin
        found = 1'b1;
        check(tag, obs_addr, addr);
      end
    end
    check({tag, "_seen"}, 32'(found), 32'd1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic found;
    logic [2:0] sel;
    logic [31:0] tgt;
    int base;

    // Reset and stream: zero-wait memory, decode always ready.
    do_reset(2);
    cycle(1'b1, PC_SEQ, 32'd0, 0, 0);
    check("first_req", 32'(obs_req), 32'd1);
    check("first_addr", obs_addr, RST_PC);
    check("first_ack", 32'(obs_ack), 32'd1);
`ifdef FETCH_BYPASS_EN
    check("bypass_same_cycle", 32'(obs_valid), 32'd1);
`else
    check("base_latency", 32'(obs_valid), 32'd0);
`endif
    cycle(1'b1, PC_SEQ, 32'd0, 0, 0);
    check("valid_next_cycle", 32'(obs_valid), 32'd1);
    consumed = 0;
    repeat (20) cycle(1'b1, PC_SEQ, 32'd0, 0, 0);
    check("throughput", 32'(consumed), 32'd20);

    // Back-pressure: exactly QDEPTH words fetched, then requests stop.
    do_reset(1);
    acks = 0;
    repeat (10) cycle(1'b0, PC_SEQ, 32'd0, 0, 0);
    check("bp_acks", 32'(acks), 32'(QD));
    check("bp_req_low", 32'(obs_req), 32'd0);
    check("bp_head_valid", 32'(obs_valid), 32'd1);
    check("bp_head_pc", obs_pc, 32'd0);
    cycle(1'b1, PC_SEQ, 32'd0, 0, 0);
    cycle(1'b1, PC_SEQ, 32'd0, 0, 0);
    check("bp_resume_req", 32'(obs_req), 32'd1);
    check("bp_resume_addr", obs_addr, 32'd16);
    base = consumed;
    repeat (8) cycle(1'b1, PC_SEQ, 32'd0, 0, 0);
    check("bp_drain", 32'(consumed - base), 32'd8);

    // Redirect while waiting for a 3-cycle-late ack.
    do_reset(1);
    cycle(1'b1, PC_JUMP, 32'h200, 3, 3);
    check("rw_req", 32'(obs_req), 32'd1);
    check("rw_no_ack", 32'(obs_ack), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, PC_SEQ, 32'd0, 3, 3);
      check("rw_addr_hold", obs_addr, 32'd0);
    end
    check("rw_ack_last", 32'(obs_ack), 32'd1);
    expect_next_req("rw_next_addr", 32'h200);

    // Redirect coinciding with an ack, unaligned target.
    do_reset(1);
    repeat (5) cycle(1'b1, PC_SEQ, 32'd0, 0, 0);
    cycle(1'b1, PC_BRANCH, 32'h43, 0, 0);
    check("ra_ack", 32'(obs_ack), 32'd1);
    cycle(1'b1, PC_SEQ, 32'd0, 0, 0);
    check("ra_queue_empty", 32'(obs_valid), 32'd0);
    expect_next_req("ra_next_addr", 32'h40);

    // Reset while a request to 0x10 is stalled.
    do_reset(1);
    cycle(1'b1, PC_JUMP, 32'h10, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      cycle(1'b1, PC_SEQ, 32'd0, 20, 20);
      found = obs_req && (obs_addr == 32'h10);
    end
    check("mr_stalled_seen", 32'(found), 32'd1);
    do_reset(1);
    expect_next_req("mr_restart_addr", RST_PC);

    // Randomized traffic: variable memory latency, back-pressure and redirects.
    do_reset(1);
    base = consumed;
    repeat (800) begin
      sel = PC_SEQ;
      if ($urandom_range(0, 15) == 0) sel = ($urandom_range(0, 1) == 0) ? PC_JUMP : PC_BRANCH;
      tgt = $urandom() & 32'h0000_0FFF;
      cycle($urandom_range(0, 3) != 0, sel, tgt, 0, 3);
    end
    check("random_progress", 32'(consumed - base > 100), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
